// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: registered multi-digit BCD up/down counter with clear, load, wrap/saturate
module bcd_updown_counter #(
    parameter int DIGITS = 6,
    parameter bit WRAP   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   load,
    input  logic [DIGITS-1:0][3:0] load_value,
    input  logic                   enable,
    input  logic                   up_dn,
    output logic [DIGITS-1:0][3:0] bcd_out,
    output logic                   wrap,
    output logic                   at_max,
    output logic                   at_min,
    output logic                   load_err
);
    logic [DIGITS-1:0][3:0] bcd_q, bcd_d, stepped, clamped;
    logic                   wrap_q, wrap_d, load_err_q, load_err_d;
    logic                   carry, clamp_any, all_nine;
    // ripple the decimal carry/borrow from digit 0; carry surviving past the top digit marks a limit
    always_comb begin
        stepped  = bcd_q;
        carry    = 1'b1;
        all_nine = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            all_nine = all_nine & (bcd_q[i] == 4'd9);
            if (carry && up_dn) begin
                stepped[i] = (bcd_q[i] == 4'd9) ? 4'd0 : bcd_q[i] + 4'd1;
                carry      = (bcd_q[i] == 4'd9);
            end else if (carry) begin
                stepped[i] = (bcd_q[i] == 4'd0) ? 4'd9 : bcd_q[i] - 4'd1;
                carry      = (bcd_q[i] == 4'd0);
            end
        end
    end
    // clamp each load digit to 9 so no illegal BCD digit ever reaches the register
    always_comb begin
        clamped   = load_value;
        clamp_any = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            clamped[i] = (load_value[i] > 4'd9) ? 4'd9 : load_value[i];
            clamp_any  = clamp_any | (load_value[i] > 4'd9);
        end
    end
    // next state with priority clear > load > enable; pulses default to 0
    always_comb begin
        bcd_d      = bcd_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            bcd_d = '0;
        end else if (load) begin
            bcd_d      = clamped;
            load_err_d = clamp_any;
        end else if (enable) begin
            bcd_d  = (carry && !WRAP) ? bcd_q : stepped;
            wrap_d = carry;
        end
    end
    // state register; reset overrides everything presented in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_q      <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            bcd_q      <= bcd_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end
    assign bcd_out  = bcd_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;
    assign at_max   = all_nine;
    assign at_min   = (bcd_q == '0);
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed self-checking bench for bcd_updown_counter
module tb_bcd_updown_counter;
    logic        clk = 1'b0;
    logic        reset = 1'b0, clear = 1'b0, load = 1'b0, enable = 1'b0, up_dn = 1'b1;
    logic [23:0] lv = '0;
    logic [11:0] a_bcd, s_bcd;
    logic [23:0] c_bcd;
    logic        a_wrap, a_max, a_min, a_err;
    logic        s_wrap, s_max, s_min, s_err;
    logic        c_wrap, c_max, c_min, c_err;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(3), .WRAP(1'b1)) u_a (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(lv[11:0]),
        .enable(enable), .up_dn(up_dn), .bcd_out(a_bcd), .wrap(a_wrap),
        .at_max(a_max), .at_min(a_min), .load_err(a_err));

    bcd_updown_counter #(.DIGITS(3), .WRAP(1'b0)) u_s (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(lv[11:0]),
        .enable(enable), .up_dn(up_dn), .bcd_out(s_bcd), .wrap(s_wrap),
        .at_max(s_max), .at_min(s_min), .load_err(s_err));

    bcd_updown_counter u_c (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(lv),
        .enable(enable), .up_dn(up_dn), .bcd_out(c_bcd), .wrap(c_wrap),
        .at_max(c_max), .at_min(c_min), .load_err(c_err));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; clear = 1'b0; load = 1'b0; enable = 1'b0; up_dn = 1'b1;
    endtask

    task automatic do_load(input logic [23:0] v);
        idle(); load = 1'b1; lv = v;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle(); reset = 1'b1; load = 1'b1; enable = 1'b1; lv = 24'h000555;
        tick();
        idle();
        tests++; if (a_bcd !== 12'h000) begin fails++; $display("FAIL reset_bcd: got %h expected 000", a_bcd); end
        tests++; if ({a_wrap, a_err, a_min, a_max} !== 4'b0010) begin fails++; $display("FAIL reset_flags: got %b expected 0010", {a_wrap, a_err, a_min, a_max}); end
    endtask

    task automatic test_count_up();
        int wraps = 0;
        logic [11:0] exp;
        idle(); reset = 1'b1;
        tick();
        idle(); enable = 1'b1; up_dn = 1'b1;
        for (int k = 1; k <= 1000; k++) begin
            tick();
            exp = {4'((k % 1000) / 100), 4'((k % 100) / 10), 4'(k % 10)};
            if (a_wrap) wraps++;
            tests++; if (a_bcd !== exp) begin fails++; $display("FAIL up_count step %0d: got %h expected %h", k, a_bcd, exp); end
            tests++; if (a_wrap !== (k == 1000)) begin fails++; $display("FAIL up_wrap step %0d: got %b expected %b", k, a_wrap, k == 1000); end
            if (k == 999) begin
                tests++; if (a_max !== 1'b1) begin fails++; $display("FAIL at_max at 999: got %b expected 1", a_max); end
            end
        end
        idle();
        tests++; if (wraps != 1) begin fails++; $display("FAIL wrap_count: got %0d expected 1", wraps); end
        tick();
        tests++; if ({a_bcd, a_wrap} !== {12'h000, 1'b0}) begin fails++; $display("FAIL hold_after_wrap: got %h/%b expected 000/0", a_bcd, a_wrap); end
    endtask

    task automatic test_down_borrow();
        do_load(24'h000109);
        enable = 1'b1; up_dn = 1'b0;
        tick();
        idle();
        tests++; if (a_bcd !== 12'h108) begin fails++; $display("FAIL down_109: got %h expected 108", a_bcd); end
        do_load(24'h000100);
        enable = 1'b1; up_dn = 1'b0;
        tick();
        idle();
        tests++; if ({a_bcd, a_wrap} !== {12'h099, 1'b0}) begin fails++; $display("FAIL down_100: got %h/%b expected 099/0", a_bcd, a_wrap); end
    endtask

    task automatic test_saturate();
        do_load(24'h000999);
        enable = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if ({s_bcd, s_wrap} !== {12'h999, 1'b1}) begin fails++; $display("FAIL sat_up %0d: got %h/%b expected 999/1", k, s_bcd, s_wrap); end
        end
        do_load(24'h000000);
        enable = 1'b1; up_dn = 1'b0;
        tick();
        idle();
        tests++; if ({s_bcd, s_wrap, s_min} !== {12'h000, 1'b1, 1'b1}) begin fails++; $display("FAIL sat_down: got %h/%b/%b expected 000/1/1", s_bcd, s_wrap, s_min); end
        tick();
        tests++; if (s_wrap !== 1'b0) begin fails++; $display("FAIL sat_wrap_clear: got %b expected 0", s_wrap); end
    endtask

    task automatic test_load_clamp();
        do_load(24'h000A5F);
        tests++; if ({a_bcd, a_err} !== {12'h959, 1'b1}) begin fails++; $display("FAIL clamp_load: got %h/%b expected 959/1", a_bcd, a_err); end
        tick();
        tests++; if ({a_bcd, a_err} !== {12'h959, 1'b0}) begin fails++; $display("FAIL clamp_pulse: got %h/%b expected 959/0", a_bcd, a_err); end
        do_load(24'h000123);
        tests++; if (a_err !== 1'b0) begin fails++; $display("FAIL legal_load_err: got %b expected 0", a_err); end
    endtask

    task automatic test_priority();
        do_load(24'h000123);
        reset = 1'b1; load = 1'b1; enable = 1'b1; lv = 24'h000777;
        tick();
        idle();
        tests++; if (a_bcd !== 12'h000) begin fails++; $display("FAIL reset_over_load: got %h expected 000", a_bcd); end
        do_load(24'h000555);
        clear = 1'b1; load = 1'b1; lv = 24'h000777;
        tick();
        idle();
        tests++; if (a_bcd !== 12'h000) begin fails++; $display("FAIL clear_over_load: got %h expected 000", a_bcd); end
        load = 1'b1; enable = 1'b1; up_dn = 1'b1; lv = 24'h000042;
        tick();
        idle();
        tests++; if (a_bcd !== 12'h042) begin fails++; $display("FAIL load_over_enable: got %h expected 042", a_bcd); end
    endtask

    task automatic test_six_digits();
        do_load(24'h999999);
        enable = 1'b1; up_dn = 1'b1;
        tick();
        tests++; if ({c_bcd, c_wrap} !== {24'h000000, 1'b1}) begin fails++; $display("FAIL six_up: got %h/%b expected 000000/1", c_bcd, c_wrap); end
        up_dn = 1'b0;
        tick();
        idle();
        tests++; if ({c_bcd, c_wrap} !== {24'h999999, 1'b1}) begin fails++; $display("FAIL six_down: got %h/%b expected 999999/1", c_bcd, c_wrap); end
        tick();
        tests++; if ({c_bcd, c_wrap, c_max} !== {24'h999999, 1'b0, 1'b1}) begin fails++; $display("FAIL six_hold: got %h/%b/%b expected 999999/0/1", c_bcd, c_wrap, c_max); end
        do_load(24'h190990);
        enable = 1'b1; up_dn = 1'b1;
        tick();
        idle();
        tests++; if (c_bcd !== 24'h190991) begin fails++; $display("FAIL six_inc: got %h expected 190991", c_bcd); end
        do_load(24'h200000);
        enable = 1'b1; up_dn = 1'b0;
        tick();
        idle();
        tests++; if (c_bcd !== 24'h199999) begin fails++; $display("FAIL six_borrow: got %h expected 199999", c_bcd); end
    endtask

    initial begin
        idle();
        tick();
        test_reset();
        test_count_up();
        test_down_borrow();
        test_saturate();
        test_load_clamp();
        test_priority();
        test_six_digits();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
